// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants, state encoding and control-word type for the multi-cycle RV32I controller.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_ECALL     = 7'b1110011;

  localparam logic       ALU_SRC_A_PC    = 1'b0;
  localparam logic       ALU_SRC_A_RS1   = 1'b1;
  localparam logic [1:0] ALU_SRC_B_RS2   = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM   = 2'd2;
  localparam logic [1:0] ALU_OP_ADD      = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT    = 2'd1;
  localparam logic [1:0] ALU_OP_BRANCH   = 2'd2;
  localparam logic       PC_SRC_ALU      = 1'b0;
  localparam logic       PC_SRC_ALUOUT   = 1'b1;

  typedef enum logic [2:0] {
    StIf,
    StId,
    StEx,
    StBrTaken,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_known_opcode(logic [6:0] opc);
    return (opc == OPC_ARITH)  || (opc == OPC_ARITH_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE)  || (opc == OPC_BRANCH)    || (opc == OPC_JAL)  ||
           (opc == OPC_JALR)   || (opc == OPC_ECALL);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 bcond;
  logic                 halt_cond;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_source;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 is_halted;
  logic [CNT_WIDTH-1:0] inst_count;

  modport master (
    input  opcode, bcond, halt_cond, mem_ready,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted, inst_count
  );

  modport slave (
    output opcode, bcond, halt_cond, mem_ready,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted, inst_count
  );
endinterface

// File: rtl/multicycle_control_fsm_microcode_outputs.sv
// Combinational decode of state, opcode and handshake inputs into datapath strobes/selects.
module multicycle_control_fsm_microcode_outputs
  import multicycle_control_fsm_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] opcode_i,
  input  logic       bcond_i,
  input  logic       halt_cond_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StIf: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ir_write = mem_ready_i;
      end
      StId: begin
        ctrl_o.alu_src_a = ALU_SRC_A_PC;
        ctrl_o.alu_src_b = ALU_SRC_B_FOUR;
        ctrl_o.alu_op    = ALU_OP_ADD;
        if ((opcode_i == OPC_ECALL) ? !halt_cond_i : !is_known_opcode(opcode_i)) begin
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PC_SRC_ALU;
        end
      end
      StEx: begin
        case (opcode_i)
          OPC_ARITH: begin
            ctrl_o.alu_src_a = ALU_SRC_A_RS1;
            ctrl_o.alu_src_b = ALU_SRC_B_RS2;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
          end
          OPC_ARITH_IMM: begin
            ctrl_o.alu_src_a = ALU_SRC_A_RS1;
            ctrl_o.alu_src_b = ALU_SRC_B_IMM;
            ctrl_o.alu_op    = ALU_OP_FUNCT;
          end
          OPC_LOAD, OPC_STORE: begin
            ctrl_o.alu_src_a = ALU_SRC_A_RS1;
            ctrl_o.alu_src_b = ALU_SRC_B_IMM;
          end
          OPC_BRANCH: begin
            ctrl_o.alu_src_a = ALU_SRC_A_RS1;
            ctrl_o.alu_src_b = ALU_SRC_B_RS2;
            ctrl_o.alu_op    = ALU_OP_BRANCH;
            // ALUOut still holds PC+4 from ID.
            ctrl_o.pc_write  = !bcond_i;
            ctrl_o.pc_source = PC_SRC_ALUOUT;
          end
          OPC_JAL, OPC_JALR: begin
            ctrl_o.alu_src_a = (opcode_i == OPC_JALR) ? ALU_SRC_A_RS1 : ALU_SRC_A_PC;
            ctrl_o.alu_src_b = ALU_SRC_B_IMM;
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.reg_write = 1'b1;
          end
          default: ;
        endcase
      end
      StBrTaken: begin
        ctrl_o.alu_src_b = ALU_SRC_B_IMM;
        ctrl_o.pc_write  = 1'b1;
      end
      StMem: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_read  = (opcode_i == OPC_LOAD);
        ctrl_o.mem_write = (opcode_i != OPC_LOAD);
        // ALUOut reloads every cycle, so keep recomputing rs1+imm to hold the address steady.
        ctrl_o.alu_src_a = ALU_SRC_A_RS1;
        ctrl_o.alu_src_b = ALU_SRC_B_IMM;
        if (mem_ready_i && (opcode_i != OPC_LOAD)) begin
          ctrl_o.alu_src_a = ALU_SRC_A_PC;
          ctrl_o.alu_src_b = ALU_SRC_B_FOUR;
          ctrl_o.pc_write  = 1'b1;
        end
      end
      StWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = (opcode_i == OPC_LOAD);
        ctrl_o.alu_src_b  = ALU_SRC_B_FOUR;
        ctrl_o.pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: state register, next-state logic and retired-instruction count.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_control_fsm_if.master bus
);

  state_e               state_q, state_d;
  logic                 is_halted_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  ctrl_t                ctrl, ctrl_out;

  multicycle_control_fsm_microcode_outputs u_microcode_outputs (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .bcond_i     (bus.bcond),
    .halt_cond_i (bus.halt_cond),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf: if (bus.mem_ready) state_d = StId;
      StId: begin
        if (bus.opcode == OPC_ECALL) begin
          state_d = bus.halt_cond ? StHalt : StIf;
        end else begin
          state_d = is_known_opcode(bus.opcode) ? StEx : StIf;
        end
      end
      StEx: begin
        case (bus.opcode)
          OPC_ARITH, OPC_ARITH_IMM: state_d = StWb;
          OPC_LOAD, OPC_STORE:      state_d = StMem;
          OPC_BRANCH:               state_d = bus.bcond ? StBrTaken : StIf;
          default:                  state_d = StIf;
        endcase
      end
      StBrTaken: state_d = StIf;
      StMem: if (bus.mem_ready) state_d = (bus.opcode == OPC_LOAD) ? StWb : StIf;
      StWb:   state_d = StIf;
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIf;
      cnt_q       <= '0;
      is_halted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_halted_q <= (state_d == StHalt);
      if (ctrl.pc_write) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign ctrl_out = reset ? '0 : ctrl;

  assign bus.pc_write   = ctrl_out.pc_write;
  assign bus.pc_source  = ctrl_out.pc_source;
  assign bus.i_or_d     = ctrl_out.i_or_d;
  assign bus.mem_read   = ctrl_out.mem_read;
  assign bus.mem_write  = ctrl_out.mem_write;
  assign bus.ir_write   = ctrl_out.ir_write;
  assign bus.reg_write  = ctrl_out.reg_write;
  assign bus.mem_to_reg = ctrl_out.mem_to_reg;
  assign bus.alu_src_a  = ctrl_out.alu_src_a;
  assign bus.alu_src_b  = ctrl_out.alu_src_b;
  assign bus.alu_op     = ctrl_out.alu_op;
  assign bus.is_halted  = is_halted_q;
  assign bus.inst_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: per-instruction cycle plans built from the ISA-level rules, compared each cycle.
module tb_multicycle_control_fsm;

  localparam logic [6:0] ARITH  = 7'b0110011;
  localparam logic [6:0] IMM    = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] ECALL  = 7'b1110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] ZERO   = 7'b0000000;

  typedef logic [12:0] vec_t;
  typedef struct {
    vec_t exp;
    bit   rdy;
    bit   req;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_WIDTH(32)) bus ();

  multicycle_control_fsm #(.CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned model_cnt = 0;

  // Bit order: pc_write pc_source i_or_d mem_read mem_write ir_write reg_write mem_to_reg a b op
  function automatic vec_t v(bit pcw, bit pcs, bit iord, bit mr, bit mw, bit irw, bit rw,
                             bit m2r, bit a, bit [1:0] b, bit [1:0] op);
    return {pcw, pcs, iord, mr, mw, irw, rw, m2r, a, b, op};
  endfunction

  function automatic vec_t observed();
    return {bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_cycle(input string tag, input vec_t exp, input bit rdy, input bit req,
                          input bit halted, output bit pcw_seen);
    bus.mem_ready = req ? rdy : 1'($urandom);
    @(negedge clk);
    check_eq({tag, "/strobes"}, observed(), exp);
    check_eq({tag, "/count"}, bus.inst_count, model_cnt);
    check_eq({tag, "/halted"}, bus.is_halted, halted);
    check_eq({tag, "/rd_wr_excl"}, bus.mem_read & bus.mem_write, 0);
    pcw_seen = bus.pc_write;
    if (exp[12]) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_latency(logic [6:0] op, bit bc, int w_if, int w_mem);
    case (op)
      ARITH, IMM:  return 4 + w_if;
      STORE:       return 4 + w_if + w_mem;
      LOAD:        return 5 + w_if + w_mem;
      BRANCH:      return (bc ? 4 : 3) + w_if;
      JAL, JALR:   return 3 + w_if;
      default:     return 2 + w_if;
    endcase
  endfunction

  task automatic push_fetch(inout step_t plan[$], input int w_if);
    repeat (w_if) plan.push_back('{v(0,0,0,1,0,0,0,0,0,2'd0,2'd0), 1'b0, 1'b1});
    plan.push_back('{v(0,0,0,1,0,1,0,0,0,2'd0,2'd0), 1'b1, 1'b1});
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input bit bc, input bit hc,
                           input int w_if, input int w_mem);
    step_t plan[$];
    vec_t  id_plain, id_retire, wb;
    int    cyc, first_pcw;
    bit    seen;
    bus.opcode    = op;
    bus.bcond     = bc;
    bus.halt_cond = hc;
    id_plain  = v(0,0,0,0,0,0,0,0,0,2'd1,2'd0);
    id_retire = v(1,0,0,0,0,0,0,0,0,2'd1,2'd0);
    wb        = v(1,0,0,0,0,0,1,op == LOAD,0,2'd1,2'd0);
    push_fetch(plan, w_if);
    case (op)
      ARITH, IMM: begin
        plan.push_back('{id_plain, 1'b0, 1'b0});
        plan.push_back('{v(0,0,0,0,0,0,0,0,1,(op == IMM) ? 2'd2 : 2'd0,2'd1), 1'b0, 1'b0});
        plan.push_back('{wb, 1'b0, 1'b0});
      end
      LOAD: begin
        plan.push_back('{id_plain, 1'b0, 1'b0});
        plan.push_back('{v(0,0,0,0,0,0,0,0,1,2'd2,2'd0), 1'b0, 1'b0});
        repeat (w_mem) plan.push_back('{v(0,0,1,1,0,0,0,0,1,2'd2,2'd0), 1'b0, 1'b1});
        plan.push_back('{v(0,0,1,1,0,0,0,0,1,2'd2,2'd0), 1'b1, 1'b1});
        plan.push_back('{wb, 1'b0, 1'b0});
      end
      STORE: begin
        plan.push_back('{id_plain, 1'b0, 1'b0});
        plan.push_back('{v(0,0,0,0,0,0,0,0,1,2'd2,2'd0), 1'b0, 1'b0});
        repeat (w_mem) plan.push_back('{v(0,0,1,0,1,0,0,0,1,2'd2,2'd0), 1'b0, 1'b1});
        plan.push_back('{v(1,0,1,0,1,0,0,0,0,2'd1,2'd0), 1'b1, 1'b1});
      end
      BRANCH: begin
        plan.push_back('{id_plain, 1'b0, 1'b0});
        plan.push_back('{v(!bc,1,0,0,0,0,0,0,1,2'd0,2'd2), 1'b0, 1'b0});
        if (bc) plan.push_back('{v(1,0,0,0,0,0,0,0,0,2'd2,2'd0), 1'b0, 1'b0});
      end
      JAL, JALR: begin
        plan.push_back('{id_plain, 1'b0, 1'b0});
        plan.push_back('{v(1,0,0,0,0,0,1,0,op == JALR,2'd2,2'd0), 1'b0, 1'b0});
      end
      default: plan.push_back('{id_retire, 1'b0, 1'b0});
    endcase
    cyc = 0;
    first_pcw = 0;
    foreach (plan[i]) begin
      do_cycle(tag, plan[i].exp, plan[i].rdy, plan[i].req, 1'b0, seen);
      cyc++;
      if (seen && first_pcw == 0) first_pcw = cyc;
    end
    check_eq({tag, "/latency"}, first_pcw, exp_latency(op, bc, w_if, w_mem));
  endtask

  initial begin
    logic [6:0] ops [10];
    logic [6:0] op;
    bit         seen;
    ops = '{ARITH, IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL, LUI, ZERO};
    bus.opcode    = ARITH;
    bus.bcond     = 1'b0;
    bus.halt_cond = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) do_cycle("reset", '0, 1'b1, 1'b0, 1'b0, seen);
    reset = 1'b0;

    run_instr("add",        ARITH,  0, 0, 0, 0);
    run_instr("load_wait",  LOAD,   0, 0, 2, 3);
    run_instr("beq_nt",     BRANCH, 0, 0, 0, 0);
    run_instr("beq_t",      BRANCH, 1, 0, 0, 0);
    run_instr("jal",        JAL,    0, 0, 0, 0);
    run_instr("jalr",       JALR,   1, 1, 0, 0);
    run_instr("ecall_nohalt", ECALL, 0, 0, 0, 0);
    run_instr("unknown",    LUI,    0, 1, 1, 0);

    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 9)];
      run_instr("rand", op, 1'($urandom), (op == ECALL) ? 1'b0 : 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset during a STORE memory wait.
    bus.opcode = STORE;
    do_cycle("rst_if", v(0,0,0,1,0,1,0,0,0,2'd0,2'd0), 1'b1, 1'b1, 1'b0, seen);
    do_cycle("rst_id", v(0,0,0,0,0,0,0,0,0,2'd1,2'd0), 1'b0, 1'b0, 1'b0, seen);
    do_cycle("rst_ex", v(0,0,0,0,0,0,0,0,1,2'd2,2'd0), 1'b0, 1'b0, 1'b0, seen);
    do_cycle("rst_mem", v(0,0,1,0,1,0,0,0,1,2'd2,2'd0), 1'b0, 1'b1, 1'b0, seen);
    reset = 1'b1;
    do_cycle("rst_active", '0, 1'b0, 1'b0, 1'b0, seen);
    reset = 1'b0;
    model_cnt = 0;
    do_cycle("rst_after", v(0,0,0,1,0,0,0,0,0,2'd0,2'd0), 1'b0, 1'b1, 1'b0, seen);
    run_instr("post_rst_add", ARITH, 0, 0, 0, 0);
    run_instr("post_rst_store", STORE, 0, 0, 1, 2);

    // Halting ECALL: absorbing, silent, count frozen.
    bus.opcode    = ECALL;
    bus.halt_cond = 1'b1;
    do_cycle("halt_if", v(0,0,0,1,0,1,0,0,0,2'd0,2'd0), 1'b1, 1'b1, 1'b0, seen);
    do_cycle("halt_id", v(0,0,0,0,0,0,0,0,0,2'd1,2'd0), 1'b0, 1'b0, 1'b0, seen);
    for (int i = 0; i < 20; i++) begin
      bus.opcode    = ops[$urandom_range(0, 9)];
      bus.bcond     = 1'($urandom);
      bus.halt_cond = 1'($urandom);
      do_cycle("halted", '0, 1'b0, 1'b0, 1'b1, seen);
    end
    reset = 1'b1;
    do_cycle("unhalt_rst", '0, 1'b0, 1'b0, 1'b1, seen);
    reset = 1'b0;
    model_cnt = 0;
    run_instr("after_halt", IMM, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
